mvm3_stream_arbiter: RTL and testbench
======================================

// Module: mvm3_stream_arbiter
// PURPOSE
//  Shares one 3x3 matrix-vector multiply engine between two input streams. Grants one
//  requester a whole packet at a time (9 matrix + 3 vector bytes), round-robin, and feeds it
//  to the engine input handshake. Routes each packet's 3 results (plus overflow) back to the
//  owning requester. Sits between the two stream sources and the engine in the system top.
// PARAMETERS
//  DW        8   input element width (signed)
//  OW        16  result width (signed)
//  PKT_LEN   12  input beats per packet (9 matrix + 3 vector)
//  RES_LEN   3   result beats per packet
//  TAG_DEPTH 4   max packets granted but not fully returned (power of 2, >=2)
// PORTS
//  clk           in  1   clock, all logic on posedge
//  reset         in  1   synchronous, active-low
//  in0_valid     in  1   requester 0 beat valid
//  in0_ready     out 1   requester 0 beat accepted
//  in0_data      in  DW  requester 0 beat
//  in1_valid/in1_ready/in1_data    same as above, requester 1
//  eng_valid     out 1   to engine s_valid
//  eng_ready     in  1   from engine s_ready
//  eng_data      out DW  to engine data_in
//  res_valid     in  1   from engine m_valid
//  res_ready     out 1   to engine m_ready
//  res_data      in  OW  from engine data_out
//  res_ovf       in  1   from engine overflow, sampled with res_data
//  out0_valid    out 1   result valid to requester 0
//  out0_ready    in  1   requester 0 accepts result
//  out0_data     out OW  result
//  out0_ovf      out 1   overflow flag for out0_data
//  out1_valid/out1_ready/out1_data/out1_ovf   same as above, requester 1
//  err_orphan    out 1   sticky: engine offered a result with no outstanding packet
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//   - FSM->IDLE; beat_cnt=0, res_cnt=0; tag FIFO empty; priority->req0; err_orphan=0.
//   - All valid/ready outputs 0 while in reset and in the first cycle after it.
//   - Reset mid-packet aborts the packet and discards all tags. Engine reset must be asserted together with this block.
//  Input FSM: IDLE / FWD.
//   - IDLE: in_ready=0, eng_valid=0. If any inX_valid and tag FIFO not full: grant the
//     requester (tie -> priority holder), push its id to tag FIFO, go FWD next cycle.
//   - FIFO full blocks grant even if a pop happens the same cycle. Exactly 1 bubble cycle per packet.
//   - FWD: combinational pass-through: eng_valid=inG_valid, eng_data=inG_data, inG_ready=eng_ready.
//     Non-granted in_ready=0. beat_cnt++ on eng_valid&eng_ready.
//   - On handshake with beat_cnt==PKT_LEN-1: beat_cnt->0, go IDLE, priority->other requester.
//   - A granted packet is never preempted. The other requester waits regardless of its valid.
//  Result return (independent of input FSM, runs concurrently):
//   - Head tag H selects the port: outH_valid=res_valid & !empty; outH_data=res_data;
//     outH_ovf=res_ovf; res_ready=outH_ready & !empty. The other out_valid=0.
//   - res_cnt++ on res_valid&res_ready. On handshake with res_cnt==RES_LEN-1: res_cnt->0, pop tag.
//   - Push and pop in the same cycle are allowed; occupancy is unchanged.
//   - res_valid while FIFO empty: res_ready=0 (engine stalls); err_orphan<=1 until reset.
//  Results return in grant order. No data is dropped or duplicated. out_data is unmodified.
//  Latency: grant 1 cycle after valid seen in IDLE; no added latency on data paths (combinational).
// TESTING
//  1 Only req0 sends packet M=[1..9],x=[1,1,1], eng/out always ready -> out0 gets 6,15,24; out1_valid never 1.
//  2 Both valid from reset, each sends 2 packets -> grant order 0,1,0,1. Results land on matching port in that order.
//  3 Random eng_ready/out_ready/in_valid toggling, 30 packets -> outputs match golden model, no beat lost.
//  4 Hold out0_ready=0 with TAG_DEPTH=4 -> exactly 4 grants, then IDLE stalls; 5th grant 1 cycle after first tag pop.
//  5 Drive res_valid=1 with no packet granted -> res_ready=0, err_orphan=1 next cycle, stays 1 until reset.
//  6 Assert reset at beat 5 of a packet -> next cycle all valids/readies 0, FIFO empty, next grant goes to req0.

Source files
------------

// File: rtl/mvm3_stream_arbiter.sv
// Round-robin packet arbiter sharing one 3x3 MVM engine between two streams.
// Result beats are steered back to the owning requester via a tag FIFO.
module mvm3_stream_arbiter #(
  parameter int DW        = 8,
  parameter int OW        = 16,
  parameter int PKT_LEN   = 12,
  parameter int RES_LEN   = 3,
  parameter int TAG_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in0_valid,
  output logic          in0_ready,
  input  logic [DW-1:0] in0_data,
  input  logic          in1_valid,
  output logic          in1_ready,
  input  logic [DW-1:0] in1_data,
  output logic          eng_valid,
  input  logic          eng_ready,
  output logic [DW-1:0] eng_data,
  input  logic          res_valid,
  output logic          res_ready,
  input  logic [OW-1:0] res_data,
  input  logic          res_ovf,
  output logic          out0_valid,
  input  logic          out0_ready,
  output logic [OW-1:0] out0_data,
  output logic          out0_ovf,
  output logic          out1_valid,
  input  logic          out1_ready,
  output logic [OW-1:0] out1_data,
  output logic          out1_ovf,
  output logic          err_orphan
);

  localparam int BW = $clog2(PKT_LEN + 1);
  localparam int RW = $clog2(RES_LEN + 1);
  localparam int AW = $clog2(TAG_DEPTH);

  typedef enum logic {IDLE, FWD} state_t;

  state_t        state, state_nx;
  logic          gnt, gnt_nx;
  logic          prio, prio_nx;
  logic [BW-1:0] beat_cnt, beat_nx;
  logic [RW-1:0] res_cnt;
  logic          tag_mem [TAG_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, head;
  logic          push, sel, pop;
  logic          eng_v, in0_r, in1_r;
  logic          res_hs;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = tag_mem[rd_ptr[AW-1:0]];

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    prio_nx  = prio;
    beat_nx  = beat_cnt;
    push     = 1'b0;
    sel      = 1'b0;
    eng_v    = 1'b0;
    eng_data = '0;
    in0_r    = 1'b0;
    in1_r    = 1'b0;
    unique case (state)
      IDLE: begin
        // full is the registered occupancy: a same-cycle pop never frees a slot
        if ((in0_valid || in1_valid) && !full) begin
          sel      = (in0_valid && in1_valid) ? prio : in1_valid;
          push     = 1'b1;
          gnt_nx   = sel;
          state_nx = FWD;
        end
      end
      FWD: begin
        eng_v    = gnt ? in1_valid : in0_valid;
        eng_data = gnt ? in1_data : in0_data;
        in0_r    = !gnt && eng_ready;
        in1_r    = gnt && eng_ready;
        if (eng_v && eng_ready) begin
          if (beat_cnt == BW'(PKT_LEN - 1)) begin
            beat_nx  = '0;
            state_nx = IDLE;
            prio_nx  = ~gnt;
          end else begin
            beat_nx = beat_cnt + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign eng_valid = eng_v & reset;
  assign in0_ready = in0_r & reset;
  assign in1_ready = in1_r & reset;

  assign out0_valid = res_valid & !empty & !head & reset;
  assign out1_valid = res_valid & !empty & head & reset;
  assign out0_data  = res_data;
  assign out1_data  = res_data;
  assign out0_ovf   = res_ovf;
  assign out1_ovf   = res_ovf;
  assign res_ready  = (head ? out1_ready : out0_ready) & !empty & reset;

  assign res_hs = res_valid & res_ready;
  assign pop    = res_hs & (res_cnt == RW'(RES_LEN - 1));

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr[AW-1:0]] <= sel;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      gnt        <= 1'b0;
      prio       <= 1'b0;
      beat_cnt   <= '0;
      res_cnt    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      err_orphan <= 1'b0;
    end else begin
      state    <= state_nx;
      gnt      <= gnt_nx;
      prio     <= prio_nx;
      beat_cnt <= beat_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (res_hs) res_cnt <= pop ? '0 : res_cnt + 1'b1;
      if (res_valid && empty) err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mvm3_stream_arbiter.sv
// Bench for mvm3_stream_arbiter: stream sources, an engine stub and
// per-port result scoreboards driven by scenario tasks.
module tb_mvm3_stream_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        in0_valid, in0_ready, in1_valid, in1_ready;
  logic [7:0]  in0_data, in1_data, eng_data;
  logic        eng_valid, eng_ready;
  logic        res_valid, res_ready, res_ovf;
  logic [15:0] res_data, out0_data, out1_data;
  logic        out0_valid, out0_ready, out0_ovf;
  logic        out1_valid, out1_ready, out1_ovf;
  logic        err_orphan;

  mvm3_stream_arbiter dut (
    .clk(clk), .reset(reset),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_data(in0_data),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data),
    .eng_valid(eng_valid), .eng_ready(eng_ready), .eng_data(eng_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_ovf(res_ovf),
    .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out0_data(out0_data), .out0_ovf(out0_ovf),
    .out1_valid(out1_valid), .out1_ready(out1_ready),
    .out1_data(out1_data), .out1_ovf(out1_ovf),
    .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [7:0]  sq0[$], sq1[$], ebuf[$];
  logic [16:0] eq[$], exp0[$], exp1[$];
  int gq[$];
  int p_in = 100, p_eng = 100, p_out = 100;
  bit hold0 = 0, force_mode = 0, f_valid = 0, seen_out1 = 0;
  int n_beats = 0, n_out0 = 0, n_out1 = 0;

  function automatic logic [16:0] calc(input logic [7:0] b[12], input int row);
    int s;
    logic signed [7:0] a, v;
    s = 0;
    for (int j = 0; j < 3; j++) begin
      a = b[3*row+j];
      v = b[9+j];
      s += a * v;
    end
    return {(s > 32767 || s < -32768), s[15:0]};
  endfunction

  function automatic bit rnd(input int p);
    return $urandom_range(99) < p;
  endfunction

  always @(posedge clk) cyc++;

  // stimulus driver: updates well after the active edge
  always @(posedge clk) begin
    #2;
    in0_valid  = sq0.size() > 0 && rnd(p_in);
    in0_data   = sq0.size() > 0 ? sq0[0] : 8'h00;
    in1_valid  = sq1.size() > 0 && rnd(p_in);
    in1_data   = sq1.size() > 0 ? sq1[0] : 8'h00;
    eng_ready  = rnd(p_eng);
    out0_ready = !hold0 && rnd(p_out);
    out1_ready = rnd(p_out);
    if (force_mode) res_valid = f_valid;
    else res_valid = eq.size() > 0 && rnd(p_eng);
    res_data = eq.size() > 0 ? eq[0][15:0] : 16'h0;
    res_ovf  = eq.size() > 0 && eq[0][16];
  end

  // mid-cycle monitor: engine stub, source pops and result scoreboard
  always @(negedge clk) begin
    if (reset) begin
      if (eng_valid && eng_ready) begin
        logic [7:0] pk[12];
        if (ebuf.size() == 0) gq.push_back(in1_ready ? 1 : 0);
        ebuf.push_back(eng_data);
        n_beats++;
        if (ebuf.size() == 12) begin
          for (int k = 0; k < 12; k++) pk[k] = ebuf[k];
          for (int r = 0; r < 3; r++) eq.push_back(calc(pk, r));
          ebuf.delete();
        end
      end
      if (in0_valid && in0_ready) void'(sq0.pop_front());
      if (in1_valid && in1_ready) void'(sq1.pop_front());
      if (!force_mode && res_valid && res_ready) void'(eq.pop_front());
      if (out1_valid) seen_out1 = 1;
      if (out0_valid && exp0.size() == 0) begin
        checks++; failures++;
        $display("FAIL out0_spurious got=%h expected=none", out0_data);
      end else if (out0_valid && out0_ready) begin
        checks++;
        if ({out0_ovf, out0_data} !== exp0[0]) begin
          failures++;
          $display("FAIL out0_data got=%h expected=%h", {out0_ovf, out0_data}, exp0[0]);
        end
        void'(exp0.pop_front());
        n_out0++;
      end
      if (out1_valid && exp1.size() == 0) begin
        checks++; failures++;
        $display("FAIL out1_spurious got=%h expected=none", out1_data);
      end else if (out1_valid && out1_ready) begin
        checks++;
        if ({out1_ovf, out1_data} !== exp1[0]) begin
          failures++;
          $display("FAIL out1_data got=%h expected=%h", {out1_ovf, out1_data}, exp1[0]);
        end
        void'(exp1.pop_front());
        n_out1++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_models();
    sq0.delete(); sq1.delete(); ebuf.delete(); eq.delete();
    exp0.delete(); exp1.delete(); gq.delete();
  endtask

  task automatic send_pkt(input int p, input logic [7:0] b[12]);
    for (int k = 0; k < 12; k++)
      if (p == 0) sq0.push_back(b[k]);
      else sq1.push_back(b[k]);
    for (int r = 0; r < 3; r++)
      if (p == 0) exp0.push_back(calc(b, r));
      else exp1.push_back(calc(b, r));
  endtask

  task automatic rand_pkt(input int p);
    logic [7:0] b[12];
    for (int k = 0; k < 12; k++) b[k] = 8'($urandom);
    send_pkt(p, b);
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    bit done = 0;
    while (!done && n < budget) begin
      done = sq0.size() == 0 && sq1.size() == 0 && ebuf.size() == 0 &&
             eq.size() == 0 && exp0.size() == 0 && exp1.size() == 0;
      if (!done) begin tick(); n++; end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_drain pending exp0=%0d exp1=%0d expected=0", name, exp0.size(), exp1.size());
    end
  endtask

  task automatic test_reset();
    logic [7:0] b[12];
    b = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd1, 8'd1, 8'd1};
    reset = 1'b0;
    force_mode = 1; f_valid = 1;
    send_pkt(0, b);
    repeat (3) tick();
    checks++;
    if ({in0_ready, in1_ready, eng_valid, res_ready, out0_valid, out1_valid, err_orphan} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b expected=0",
        {in0_ready, in1_ready, eng_valid, res_ready, out0_valid, out1_valid, err_orphan});
    end
    force_mode = 0; f_valid = 0;
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if ({in0_valid, in0_ready, eng_valid, res_ready, out0_valid, out1_valid} !== 6'b100000) begin
      failures++;
      $display("FAIL post_reset_idle got=%b expected=100000",
        {in0_valid, in0_ready, eng_valid, res_ready, out0_valid, out1_valid});
    end
  endtask

  task automatic test_single();
    int o0 = n_out0;
    seen_out1 = 0;
    drain(500, "single");
    checks++;
    if (n_out0 - o0 !== 3) begin
      failures++;
      $display("FAIL single_count got=%0d expected=3", n_out0 - o0);
    end
    checks++;
    if (seen_out1 !== 1'b0) begin
      failures++;
      $display("FAIL single_out1_valid got=%b expected=0", seen_out1);
    end
  endtask

  task automatic test_alternate();
    int eg[4] = '{0, 1, 0, 1};
    logic [7:0] b[12];
    for (int k = 0; k < 12; k++) b[k] = 8'h80;
    reset = 1'b0;
    clear_models();
    rand_pkt(0); rand_pkt(1);
    send_pkt(0, b); rand_pkt(1);
    repeat (3) tick();
    reset = 1'b1;
    drain(1000, "alternate");
    checks++;
    if (gq.size() !== 4) begin
      failures++;
      $display("FAIL alt_grant_count got=%0d expected=4", gq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (gq[i] !== eg[i]) begin
          failures++;
          $display("FAIL alt_grant_%0d got=%0d expected=%0d", i, gq[i], eg[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    int b0 = n_beats;
    int r0 = n_out0 + n_out1;
    p_in = 60; p_eng = 70; p_out = 70;
    for (int i = 0; i < 30; i++) rand_pkt(int'($urandom_range(1)));
    drain(20000, "random");
    checks++;
    if (n_beats - b0 !== 360) begin
      failures++;
      $display("FAIL random_beats got=%0d expected=360", n_beats - b0);
    end
    checks++;
    if (n_out0 + n_out1 - r0 !== 90) begin
      failures++;
      $display("FAIL random_results got=%0d expected=90", n_out0 + n_out1 - r0);
    end
    p_in = 100; p_eng = 100; p_out = 100;
  endtask

  task automatic test_backpressure();
    int b0, o0, cp, cg, n;
    bit ok;
    hold0 = 1;
    b0 = n_beats;
    for (int i = 0; i < 5; i++) rand_pkt(0);
    repeat (200) tick();
    checks++;
    if (n_beats - b0 !== 48) begin
      failures++;
      $display("FAIL bp_grants got=%0d beats expected=48", n_beats - b0);
    end
    checks++;
    if ({in0_valid, in0_ready} !== 2'b10) begin
      failures++;
      $display("FAIL bp_stall got=%b expected=10", {in0_valid, in0_ready});
    end
    o0 = n_out0;
    hold0 = 0;
    cp = 0; cg = 0; n = 0; ok = 0;
    while (!ok && n < 100) begin
      tick(); n++;
      if (n_out0 - o0 >= 3) begin ok = 1; cp = cyc; end
    end
    n = 0;
    while (ok && !in0_ready && n < 50) begin tick(); n++; end
    cg = cyc;
    checks++;
    if (!ok || !in0_ready || cg - cp !== 2) begin
      failures++;
      $display("FAIL bp_fifth_grant got=%0d cycles expected=2", cg - cp);
    end
    drain(1000, "backpressure");
  endtask

  task automatic test_orphan();
    force_mode = 1; f_valid = 1;
    tick();
    checks++;
    if ({res_valid, res_ready, err_orphan} !== 3'b100) begin
      failures++;
      $display("FAIL orphan_stall got=%b expected=100", {res_valid, res_ready, err_orphan});
    end
    tick();
    checks++;
    if (err_orphan !== 1'b1) begin
      failures++;
      $display("FAIL orphan_flag got=%b expected=1", err_orphan);
    end
    f_valid = 0; force_mode = 0;
    repeat (5) tick();
    checks++;
    if (err_orphan !== 1'b1) begin
      failures++;
      $display("FAIL orphan_sticky got=%b expected=1", err_orphan);
    end
  endtask

  task automatic test_reset_mid();
    int eg[2] = '{0, 1};
    int n = 0;
    gq.delete();
    rand_pkt(1);
    while (ebuf.size() < 5 && n < 100) begin tick(); n++; end
    checks++;
    if (ebuf.size() < 5) begin
      failures++;
      $display("FAIL mid_reach_beat5 got=%0d expected=5", ebuf.size());
    end
    reset = 1'b0;
    clear_models();
    tick();
    checks++;
    if ({in0_ready, in1_ready, eng_valid, res_ready, out0_valid, out1_valid, err_orphan} !== 7'b0) begin
      failures++;
      $display("FAIL mid_reset_outputs got=%b expected=0",
        {in0_ready, in1_ready, eng_valid, res_ready, out0_valid, out1_valid, err_orphan});
    end
    rand_pkt(0); rand_pkt(1);
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if ({in0_ready, in1_ready, eng_valid} !== 3'b0) begin
      failures++;
      $display("FAIL mid_post_reset got=%b expected=0", {in0_ready, in1_ready, eng_valid});
    end
    drain(1000, "reset_mid");
    checks++;
    if (gq.size() !== 2) begin
      failures++;
      $display("FAIL mid_grant_count got=%0d expected=2", gq.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (gq[i] !== eg[i]) begin
          failures++;
          $display("FAIL mid_grant_%0d got=%0d expected=%0d", i, gq[i], eg[i]);
        end
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    in0_valid = 0; in0_data = 0; in1_valid = 0; in1_data = 0;
    eng_ready = 0; res_valid = 0; res_data = 0; res_ovf = 0;
    out0_ready = 0; out1_ready = 0;
    test_reset();
    test_single();
    test_alternate();
    test_random();
    test_backpressure();
    test_orphan();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
